// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus slaves.
// Build option SERIAL_SLAVE_SPLIT_EN adds the split-release states (StSplit, StResume).
package bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StWdata,
    StRdata,
`ifdef SERIAL_SLAVE_SPLIT_EN
    StSplit,
    StResume
`else
    StRwait
`endif
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Bits needed to hold values 0..max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : unsigned'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Word-wide single-port storage: synchronous write, combinational read.
module slave_mem
  import bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned ADDR_W     = cnt_width(MEM_DEPTH - 1)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/serial_burst_slave.sv
// Serial burst slave: LSB-first address/length/data request, incrementing bursts with wrap.
// Define SERIAL_SLAVE_SPLIT_EN to release the bus (ssplit) during the read wait.
module serial_burst_slave
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BURST_WIDTH  = 4,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic swdata,
  input  logic smode,
  input  logic mvalid,
  output logic srdata,
  output logic svalid,
  output logic sready,
  output logic ssplit,
  output logic serr
);

`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  localparam int unsigned MaxAB    = (ADDR_WIDTH > BURST_WIDTH) ? ADDR_WIDTH : BURST_WIDTH;
  localparam int unsigned MaxField = (MaxAB > DATA_WIDTH) ? MaxAB : DATA_WIDTH;
  localparam int unsigned CntW     = cnt_width(MaxField);
  localparam int unsigned LatW     = cnt_width(READ_LATENCY);
  localparam int unsigned MemAw    = cnt_width(MEM_DEPTH - 1);

  localparam logic [CntW-1:0]       AddrEnd  = CntW'(ADDR_WIDTH - 1);
  localparam logic [CntW-1:0]       LenEnd   = CntW'(BURST_WIDTH - 1);
  localparam logic [CntW-1:0]       DataEnd  = CntW'(DATA_WIDTH - 1);
  localparam logic [LatW-1:0]       LatEnd   = LatW'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthCmp = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_e                  r_state, w_state_d;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_d;
  logic [BURST_WIDTH-1:0]  r_len, w_len_d;
  logic [BURST_WIDTH-1:0]  r_beat, w_beat_d;
  logic [CntW-1:0]         r_bitcnt, w_bitcnt_d;
  logic [LatW-1:0]         r_lat, w_lat_d;
  logic                    r_mode, w_mode_d;
  logic [DATA_WIDTH-1:0]   r_wshift, w_wshift_d;
  logic [DATA_WIDTH-1:0]   r_rshift, w_rshift_d;
  logic                    r_svalid, w_svalid_d;
  logic                    r_sready, w_sready_d;
  logic                    r_serr, w_serr_d;
  logic                    r_ssplit, w_ssplit_d;

  logic                    w_go_idle, w_load, w_we;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic [DATA_WIDTH-1:0]   w_wword, w_rdata;
  logic                    w_addr_oob;

  assign w_addr_inc = (r_addr == AddrLast) ? '0 : r_addr + 1'b1;
  assign w_addr_oob = ({1'b0, r_addr} >= DepthCmp);
  assign w_wword    = {swdata, r_wshift[DATA_WIDTH-1:1]};

  slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_W     (MemAw)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (r_addr[MemAw-1:0]),
    .i_wdata (w_wword),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_d  = r_state;
    w_addr_d   = r_addr;
    w_len_d    = r_len;
    w_beat_d   = r_beat;
    w_bitcnt_d = r_bitcnt;
    w_lat_d    = r_lat;
    w_mode_d   = r_mode;
    w_wshift_d = r_wshift;
    w_rshift_d = r_rshift;
    w_svalid_d = r_svalid;
    w_sready_d = r_sready;
    w_serr_d   = r_serr;
    w_ssplit_d = 1'b0;
    w_go_idle  = 1'b0;
    w_load     = 1'b0;
    w_we       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (mvalid) begin
          w_addr_d   = {swdata, r_addr[ADDR_WIDTH-1:1]};
          w_mode_d   = smode;
          w_bitcnt_d = CntW'(1);
          w_sready_d = 1'b0;
          w_state_d  = StAddr;
        end
      end
      StAddr: begin
        if (!mvalid) begin
          w_go_idle = 1'b1;
        end else begin
          w_addr_d = {swdata, r_addr[ADDR_WIDTH-1:1]};
          if (r_bitcnt == AddrEnd) begin
            w_bitcnt_d = '0;
            w_state_d  = StLen;
          end else begin
            w_bitcnt_d = r_bitcnt + 1'b1;
          end
        end
      end
      StLen: begin
        if (!mvalid) begin
          w_go_idle = 1'b1;
        end else begin
          w_len_d = {swdata, r_len[BURST_WIDTH-1:1]};
          if (r_bitcnt == LenEnd) begin
            w_bitcnt_d = '0;
            w_beat_d   = '0;
            w_lat_d    = '0;
            w_serr_d   = w_addr_oob;
            if (r_mode == MODE_WRITE) begin
              w_state_d = StWdata;
            end else begin
`ifdef SERIAL_SLAVE_SPLIT_EN
              w_state_d  = StSplit;
              w_ssplit_d = 1'b1;
`else
              w_state_d  = StRwait;
`endif
            end
          end else begin
            w_bitcnt_d = r_bitcnt + 1'b1;
          end
        end
      end
      StWdata: begin
        if (!mvalid) begin
          w_go_idle = 1'b1;
        end else begin
          w_wshift_d = w_wword;
          if (r_bitcnt == DataEnd) begin
            w_we       = ~r_serr;
            w_addr_d   = w_addr_inc;
            w_bitcnt_d = '0;
            if (r_beat == r_len) begin
              w_go_idle = 1'b1;
            end else begin
              w_beat_d = r_beat + 1'b1;
            end
          end else begin
            w_bitcnt_d = r_bitcnt + 1'b1;
          end
        end
      end
`ifdef SERIAL_SLAVE_SPLIT_EN
      StSplit: begin
        if (r_lat == LatEnd) begin
          w_state_d = StResume;
        end else begin
          w_ssplit_d = 1'b1;
          w_lat_d    = r_lat + 1'b1;
        end
      end
      StResume: w_load = 1'b1;
`else
      StRwait: begin
        if (!mvalid) begin
          w_go_idle = 1'b1;
        end else if (r_lat == LatEnd) begin
          w_load = 1'b1;
        end else begin
          w_lat_d = r_lat + 1'b1;
        end
      end
`endif
      StRdata: begin
        // A split master has handed the bus over, so mvalid no longer matters here.
        if (!mvalid && !SplitEn) begin
          w_go_idle = 1'b1;
        end else if (r_bitcnt == DataEnd) begin
          if (r_beat == r_len) begin
            w_go_idle = 1'b1;
          end else begin
            w_beat_d = r_beat + 1'b1;
            w_load   = 1'b1;
          end
        end else begin
          w_rshift_d = {1'b0, r_rshift[DATA_WIDTH-1:1]};
          w_bitcnt_d = r_bitcnt + 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_load) begin
      w_rshift_d = r_serr ? '0 : w_rdata;
      w_addr_d   = w_addr_inc;
      w_bitcnt_d = '0;
      w_svalid_d = 1'b1;
      w_state_d  = StRdata;
    end

    if (w_go_idle) begin
      w_state_d  = StIdle;
      w_sready_d = 1'b1;
      w_svalid_d = 1'b0;
      w_serr_d   = 1'b0;
      w_ssplit_d = 1'b0;
      w_rshift_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_bitcnt <= '0;
      r_lat    <= '0;
      r_mode   <= MODE_READ;
      r_wshift <= '0;
      r_rshift <= '0;
      r_svalid <= 1'b0;
      r_sready <= 1'b1;
      r_serr   <= 1'b0;
      r_ssplit <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_addr   <= w_addr_d;
      r_len    <= w_len_d;
      r_beat   <= w_beat_d;
      r_bitcnt <= w_bitcnt_d;
      r_lat    <= w_lat_d;
      r_mode   <= w_mode_d;
      r_wshift <= w_wshift_d;
      r_rshift <= w_rshift_d;
      r_svalid <= w_svalid_d;
      r_sready <= w_sready_d;
      r_serr   <= w_serr_d;
      r_ssplit <= w_ssplit_d;
    end
  end

  assign srdata = r_rshift[0];
  assign svalid = r_svalid;
  assign sready = r_sready;
  assign ssplit = r_ssplit;
  assign serr   = r_serr;

endmodule

// File: tb/tb_serial_burst_slave.sv
// Directed bench for serial_burst_slave; a second instance with MEM_DEPTH=2048 covers serr.
module tb_serial_burst_slave;
  import bus_pkg::*;

  localparam int A  = 12;
  localparam int B  = 4;
  localparam int D  = 8;
  localparam int RL = 4;
`ifdef SERIAL_SLAVE_SPLIT_EN
  localparam int SplitEn = 1;
`else
  localparam int SplitEn = 0;
`endif
  localparam int ReqEnd   = A + B - 1;
  localparam int RiseEdge = ReqEnd + RL + SplitEn;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic swdata = 1'b0;
  logic smode = 1'b0;
  logic mvalid = 1'b0;
  logic srdata0, svalid0, sready0, ssplit0, serr0;
  logic srdata1, svalid1, sready1, ssplit1, serr1;

  int n_checks = 0;
  int n_fail = 0;

  serial_burst_slave #(
    .ADDR_WIDTH(A), .DATA_WIDTH(D), .BURST_WIDTH(B), .MEM_DEPTH(4096), .READ_LATENCY(RL)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata0), .svalid(svalid0), .sready(sready0), .ssplit(ssplit0), .serr(serr0)
  );

  serial_burst_slave #(
    .ADDR_WIDTH(A), .DATA_WIDTH(D), .BURST_WIDTH(B), .MEM_DEPTH(2048), .READ_LATENCY(RL)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata1), .svalid(svalid1), .sready(sready1), .ssplit(ssplit1), .serr(serr1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the following rising edge samples them.
  task automatic drive(input logic mv, input logic b, input logic mode);
    @(negedge clk);
    mvalid = mv;
    swdata = b;
    smode  = mode;
  endtask

  task automatic send_req(input logic mode, input logic [11:0] addr, input logic [3:0] len);
    for (int i = 0; i < A; i++) drive(1'b1, addr[i], mode);
    for (int i = 0; i < B; i++) drive(1'b1, len[i], mode);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [3:0] len,
                          input logic [127:0] data, output logic s0, output logic s1);
    s0 = 1'b0;
    s1 = 1'b0;
    send_req(MODE_WRITE, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      for (int i = 0; i < D; i++) begin
        drive(1'b1, data[b*D+i], MODE_WRITE);
        if (b == 0 && i == 0) begin
          s0 = serr0;
          s1 = serr1;
        end
      end
    end
    @(negedge clk);
    check_eq("wr_sready", 32'(sready0), 32'd1);
    check_eq("wr_end_serr", 32'({serr1, serr0}), 32'd0);
    mvalid = 1'b0;
  endtask

  // Drops mvalid on the edge that would sample data bit number nbits.
  task automatic do_write_abort(input logic [11:0] addr, input logic [3:0] len,
                                input logic [127:0] data, input int nbits);
    send_req(MODE_WRITE, addr, len);
    for (int k = 0; k < nbits; k++) drive(1'b1, data[k], MODE_WRITE);
    drive(1'b0, 1'b0, MODE_READ);
    check_eq("abt_busy", 32'(sready0), 32'd0);
    @(negedge clk);
    check_eq("abt_sready", 32'(sready0), 32'd1);
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [3:0] len, input bit toggle,
                         output logic [127:0] d0, output logic [127:0] d1, output int rise,
                         output int nvalid, output int end_e, output int split_cnt,
                         output int split_rise, output logic s0, output logic s1);
    bit done;
    done = 1'b0;
    d0 = '0;
    d1 = '0;
    rise = -1;
    nvalid = 0;
    end_e = -1;
    split_cnt = 0;
    split_rise = -1;
    s0 = 1'b0;
    s1 = 1'b0;
    send_req(MODE_READ, addr, len);
    for (int e = ReqEnd; e < ReqEnd + 300; e++) begin
      @(negedge clk);
      if (e == ReqEnd) begin
        s0 = serr0;
        s1 = serr1;
      end
      if (ssplit0) begin
        if (split_rise < 0) split_rise = e;
        split_cnt++;
        if (toggle) mvalid = ~mvalid;
      end
      if (svalid0) begin
        if (rise < 0) rise = e;
        if (nvalid < 128) begin
          d0[nvalid] = srdata0;
          d1[nvalid] = srdata1;
        end
        nvalid++;
      end
      if (sready0) begin
        end_e = e;
        done = 1'b1;
        mvalid = 1'b0;
        check_eq("rd_end_svalid", 32'(svalid0), 32'd0);
        break;
      end
    end
    if (!done) begin
      mvalid = 1'b0;
      check_eq("rd_timeout", 32'(done), 32'd1);
    end
  endtask

  logic [127:0] d0, d1;
  int rise, nv, ee, sc, sr, seen;
  logic s0, s1;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_sready", 32'(sready0), 32'd1);
    check_eq("rst_svalid", 32'(svalid0), 32'd0);
    check_eq("rst_srdata", 32'(srdata0), 32'd0);
    check_eq("rst_serr", 32'(serr0), 32'd0);
    check_eq("rst_ssplit", 32'(ssplit0), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single-beat write then read.
    do_write(12'h4D5, 4'd0, 128'hD5, s0, s1);
    do_read(12'h4D5, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t1_data", 32'(d0[7:0]), 32'hD5);
    check_eq("t1_rise", 32'(rise), 32'(RiseEdge));
    check_eq("t1_nvalid", 32'(nv), 32'd8);
    check_eq("t1_end", 32'(ee), 32'(RiseEdge + 8));
    check_eq("t1_split_cycles", 32'(sc), 32'(SplitEn * RL));

    // Burst with wrap across the top of memory.
    do_write(12'hFFE, 4'd3, 128'h44332211, s0, s1);
    do_read(12'hFFE, 4'd3, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t2_burst", d0[31:0], 32'h44332211);
    check_eq("t2_nvalid", 32'(nv), 32'd32);
    check_eq("t2_end", 32'(ee), 32'(RiseEdge + 32));
    do_read(12'h000, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t2_mem000", 32'(d0[7:0]), 32'h33);
    do_read(12'h001, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t2_mem001", 32'(d0[7:0]), 32'h44);
    do_read(12'hFFF, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t2_memfff", 32'(d0[7:0]), 32'h22);

    // Aborts: mid-beat, on the last bit, and after one completed burst beat.
    do_write(12'h010, 4'd0, 128'h3C, s0, s1);
    do_write_abort(12'h010, 4'd0, 128'hAA, 4);
    do_read(12'h010, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t3_partial", 32'(d0[7:0]), 32'h3C);
    do_write(12'h020, 4'd0, 128'h5A, s0, s1);
    do_write_abort(12'h020, 4'd0, 128'hA5, 7);
    do_read(12'h020, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t3_lastbit", 32'(d0[7:0]), 32'h5A);
    do_write(12'h031, 4'd0, 128'h77, s0, s1);
    do_write_abort(12'h030, 4'd1, 128'h0F12, 11);
    do_read(12'h030, 4'd1, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t3_burst_keep", 32'(d0[15:0]), 32'h7712);

    // Out-of-range address on the 2048-word instance.
    do_write(12'h100, 4'd0, 128'h5C, s0, s1);
    do_write(12'h900, 4'd0, 128'hFF, s0, s1);
    check_eq("t4_wr_serr1", 32'(s1), 32'd1);
    check_eq("t4_wr_serr0", 32'(s0), 32'd0);
    do_read(12'h900, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t4_rd_serr1", 32'(s1), 32'd1);
    check_eq("t4_rd_data1", 32'(d1[7:0]), 32'h00);
    check_eq("t4_rd_data0", 32'(d0[7:0]), 32'hFF);
    do_read(12'h100, 4'd0, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t4_no_alias", 32'(d1[7:0]), 32'h5C);

`ifdef SERIAL_SLAVE_SPLIT_EN
    // mvalid toggles while the bus is released.
    do_read(12'h4D5, 4'd0, 1'b1, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t5_split_cycles", 32'(sc), 32'd4);
    check_eq("t5_split_rise", 32'(sr), 32'(ReqEnd));
    check_eq("t5_rise", 32'(rise), 32'(ReqEnd + RL + 1));
    check_eq("t5_data", 32'(d0[7:0]), 32'hD5);
`endif

    // Reset in the middle of a burst read.
    seen = 0;
    send_req(MODE_READ, 12'hFFE, 4'd3);
    for (int k = 0; k < 200 && seen < 12; k++) begin
      @(negedge clk);
      if (svalid0) seen++;
    end
    check_eq("t6_reached", 32'(seen), 32'd12);
    rstn = 1'b0;
    mvalid = 1'b0;
    #1;
    check_eq("t6_svalid", 32'(svalid0), 32'd0);
    check_eq("t6_sready", 32'(sready0), 32'd1);
    #2;
    rstn = 1'b1;
    do_read(12'hFFE, 4'd3, 1'b0, d0, d1, rise, nv, ee, sc, sr, s0, s1);
    check_eq("t6_reread", d0[31:0], 32'h44332211);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
